// File: rtl/cmp_stream_stats_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cmp_stream_stats_pkg
// Purpose  : Shared FSM encoding and saturating-increment helper for the
//            frame statistics block.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package cmp_stream_stats_pkg;

  // Frame tracking states: no samples yet, accumulating, record pending.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Increment v by one, sticking at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_stream_stats_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cmp_stream_stats_if
// Purpose  : Sample stream in / result record out handshake bundle.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface cmp_stream_stats_if #(
  parameter int N     = 3,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_max;
  logic [N-1:0]     out_min;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_rises;

  // Source of samples and sink of records.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_count, out_rises
  );

  // The statistics block itself.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_min, out_count, out_rises
  );
endinterface
`default_nettype wire

// File: rtl/cmp_unsigned_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cmp_unsigned_n
// Purpose  : Combinational unsigned N-bit magnitude comparator.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module cmp_unsigned_n #(
  parameter int N = 3
) (
  input  wire logic [N-1:0] i_a,
  input  wire logic [N-1:0] i_b,
  output logic              o_gt,
  output logic              o_eq,
  output logic              o_lt
);
  assign o_gt = (i_a > i_b);
  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a < i_b);
endmodule
`default_nettype wire

// File: rtl/cmp_stream_stats.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cmp_stream_stats
// Purpose  : Per-frame max/min/count/rise statistics over a sample stream,
//            emitted as one registered record at frame end.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module cmp_stream_stats
  import cmp_stream_stats_pkg::*;
#(
  parameter int N     = 3,
  parameter int CNT_W = 8
) (
  input wire logic          clk,
  input wire logic          rst,
  cmp_stream_stats_if.slave bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_first;

  logic [N-1:0]     r_max, r_min, r_prev;
  logic [CNT_W-1:0] r_count, r_rises;
  logic [N-1:0]     r_out_max, r_out_min;
  logic [CNT_W-1:0] r_out_count, r_out_rises;

  logic             w_gt_max, w_eq_max, w_lt_max;
  logic             w_gt_min, w_eq_min, w_lt_min;
  logic             w_gt_prev, w_eq_prev, w_lt_prev;

  logic [N-1:0]     w_nmax, w_nmin;
  logic [CNT_W-1:0] w_ncount, w_nrises;
  logic [CNT_W-1:0] w_count_inc, w_rises_inc;

  cmp_unsigned_n #(.N(N)) u_cmp_max (
    .i_a(bus.in_data), .i_b(r_max),
    .o_gt(w_gt_max), .o_eq(w_eq_max), .o_lt(w_lt_max)
  );
  cmp_unsigned_n #(.N(N)) u_cmp_min (
    .i_a(bus.in_data), .i_b(r_min),
    .o_gt(w_gt_min), .o_eq(w_eq_min), .o_lt(w_lt_min)
  );
  cmp_unsigned_n #(.N(N)) u_cmp_prev (
    .i_a(bus.in_data), .i_b(r_prev),
    .o_gt(w_gt_prev), .o_eq(w_eq_prev), .o_lt(w_lt_prev)
  );

  // Only gt/lt steer the trackers; equality leaves them unchanged.
  logic w_unused;
  assign w_unused = w_eq_max ^ w_lt_max ^ w_gt_min ^ w_eq_min ^ w_eq_prev ^ w_lt_prev;

  assign w_count_inc = CNT_W'(sat_inc(32'(r_count), CNT_W));
  assign w_rises_inc = CNT_W'(sat_inc(32'(r_rises), CNT_W));

  // Next-state, ready and accept; ready depends on the state register only.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = (r_state != ST_HOLD);
    w_accept    = bus.in_valid && w_in_ready;
    w_first     = (r_state == ST_IDLE);
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (w_accept) w_state_nxt = bus.in_last ? ST_HOLD : ST_ACCUM;
      end
      ST_HOLD: begin
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Tracker values after absorbing the current sample; the first sample seeds them.
  always_comb begin
    w_nmax   = r_max;
    w_nmin   = r_min;
    w_ncount = r_count;
    w_nrises = r_rises;
    if (w_first) begin
      w_nmax   = bus.in_data;
      w_nmin   = bus.in_data;
      w_ncount = CNT_W'(1);
      w_nrises = '0;
    end else begin
      if (w_gt_max)  w_nmax   = bus.in_data;
      if (w_lt_min)  w_nmin   = bus.in_data;
      w_ncount = w_count_inc;
      if (w_gt_prev) w_nrises = w_rises_inc;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Trackers follow every accepted beat; the record is captured on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_max       <= '0;
      r_min       <= '0;
      r_prev      <= '0;
      r_count     <= '0;
      r_rises     <= '0;
      r_out_max   <= '0;
      r_out_min   <= '0;
      r_out_count <= '0;
      r_out_rises <= '0;
    end else if (w_accept) begin
      r_max   <= w_nmax;
      r_min   <= w_nmin;
      r_prev  <= bus.in_data;
      r_count <= w_ncount;
      r_rises <= w_nrises;
      if (bus.in_last) begin
        r_out_max   <= w_nmax;
        r_out_min   <= w_nmin;
        r_out_count <= w_ncount;
        r_out_rises <= w_nrises;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.out_max   = r_out_max;
  assign bus.out_min   = r_out_min;
  assign bus.out_count = r_out_count;
  assign bus.out_rises = r_out_rises;

endmodule
`default_nettype wire

// File: doc/cmp_stream_stats.md
Name: cmp_stream_stats

Overview:
- Downstream consumer of the team's n-bit magnitude comparator.
- Accepts a framed stream of unsigned N-bit samples over a valid/ready handshake. For each frame it tracks the running maximum, running minimum, sample count and rise count (samples strictly greater than the previous sample).
- At frame end it presents one registered result record on a second valid/ready interface.
- Sits between a sample source and any logger or threshold stage.

Parameters:
- N, 3, sample width in bits (unsigned).
- CNT_W, 8, width of the count and rise counters; both saturate.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept a sample.
- in_data  input  N  sample value.
- in_last  input  1  qualifies the final sample of a frame.
- out_valid  output  1  result record present.
- out_ready  input  1  consumer accepts the record.
- out_max  output  N  largest sample in the frame.
- out_min  output  N  smallest sample in the frame.
- out_count  output  CNT_W  samples in the frame, saturating.
- out_rises  output  CNT_W  count of in_data > previous sample, saturating.

Behaviour:
- Interfaces: one clock domain (clk); rst is synchronous and active-high.
- Beats: an input beat is accepted when in_valid && in_ready. An output record transfers when out_valid && out_ready.
- FSM states: IDLE (no samples in frame), ACCUM (at least one sample in frame), HOLD (record waiting).
  - IDLE: accepted beat loads max = min = prev = in_data, count = 1, rises = 0.
    - With in_last set -> HOLD.
    - Without in_last -> ACCUM.
  - ACCUM: accepted beat updates the trackers.
    - max updates when in_data > max; min updates when in_data < min. Comparison is unsigned.
    - rises += 1 when in_data > prev; prev = in_data.
    - count += 1.
    - With in_last set -> HOLD.
  - HOLD: out_valid = 1 and all out_* fields are held stable. Transfer -> IDLE.
- in_ready = (state != HOLD), driven combinationally from the state register only. in_data and in_valid are ignored in HOLD.
- Latency: out_valid rises on the clock edge that accepts the last beat, so the record is visible the cycle after that beat.
- There is at least one bubble cycle per frame: in_ready returns high the cycle after the output transfer.
- Saturation: count and rises stop at 2^CNT_W-1 and never wrap.
- Equal samples: a sample equal to the previous one is not a rise. A sample equal to the current max or min leaves that tracker unchanged.
- An in_last beat in IDLE is a 1-sample frame (count = 1).
- No empty frames: in_last can only arrive with a beat.
- Reset values: state = IDLE, in_ready = 1 (from the IDLE state), out_valid = 0, out_max = 0, out_min = 0, out_count = 0, out_rises = 0, internal prev = 0.
- Reset mid-frame or in HOLD discards the partial frame or the pending record; no output is produced for it.
- rst has priority over any simultaneous handshake.
- Out_* fields are registered. They change only when entering HOLD or on reset; the IDLE and ACCUM states do not disturb them.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, ACCUM, HOLD; 2-bit);
  - a saturating-increment function parameterised by CNT_W.
- One natural sub-module: cmp_unsigned_n, a purely combinational unsigned N-bit comparator with gt/eq/lt outputs.
  - Instantiated three times: in_data vs max, in_data vs min, in_data vs prev.

Test Plan:
- Frame 000,111,101 (last on 101), out_ready = 1 -> one record: max = 7, min = 0, count = 3, rises = 1. out_valid is high exactly 1 cycle.
- Single beat 101 with in_last, from IDLE -> max = 5, min = 5, count = 1, rises = 0. in_ready is low for 1 cycle.
- Frame 010,010,010,011 -> max = 3, min = 2, count = 4, rises = 1. Equal samples produce no rises.
- Backpressure: frame 001,000 then out_ready = 0 for 5 cycles with in_valid = 1, in_data = 111 driven -> out_valid holds with max = 1, min = 0, count = 2, rises = 0 stable. in_ready = 0 throughout, and the 111 beats are not absorbed.
- Saturation with CNT_W = 2: frame 000,001,010,011,100,101 -> count = 3, rises = 3, max = 5, min = 0.
- Reset mid-frame: accept 011,100, then assert rst for 1 cycle -> out_valid stays 0 and all outputs = 0. The next frame 110 (last) gives max = 6, min = 6, count = 1, rises = 0.
